// File: rtl/alu_mb_seq_if.sv
// Command/result bus for the multi-byte ALU sequencer.
//   master : requester side, drives cmd_* and res_ready, observes cmd_ready and res_*
//   slave  : sequencer side, drives cmd_ready and res_*, observes cmd_* and res_ready
// Command: cmd_valid/cmd_ready handshake carrying op, length, operands A/B and initial carry.
// Result : res_valid/res_ready handshake carrying the assembled word and C/V/Z/N flags.
interface alu_mb_seq_if #(
  parameter int MAX_BYTES = 4,
  parameter int LEN_W     = $clog2(MAX_BYTES) + 1
);
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [2:0]             cmd_op;
  logic [LEN_W-1:0]       cmd_len;
  logic [8*MAX_BYTES-1:0] cmd_a;
  logic [8*MAX_BYTES-1:0] cmd_b;
  logic                   cmd_ci;

  logic                   res_valid;
  logic                   res_ready;
  logic [8*MAX_BYTES-1:0] res_data;
  logic                   res_c;
  logic                   res_v;
  logic                   res_z;
  logic                   res_n;

  modport master (
    output cmd_valid, cmd_op, cmd_len, cmd_a, cmd_b, cmd_ci, res_ready,
    input  cmd_ready, res_valid, res_data, res_c, res_v, res_z, res_n
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, cmd_a, cmd_b, cmd_ci, res_ready,
    output cmd_ready, res_valid, res_data, res_c, res_v, res_z, res_n
  );
endinterface

// File: rtl/alu_mb_seq.sv
// Multi-byte arithmetic sequencer for the 8-bit 6502 ALU.
// Accepts one command of up to MAX_BYTES bytes, feeds it to the ALU one byte per
// cycle while chaining carry, collects the per-byte results and returns the
// assembled word with C/V/Z/N flags.
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   bus (slave)         : cmd_* command handshake in, res_* result handshake out
//   alu_op/right/ai/bi/ci/bcd/rdy : driven to the ALU, all 0 outside issue cycles
//   alu_out/co/v        : registered ALU results, valid the cycle after issue
//
// Optional feature macro: ALU_MB_SEQ_CMP_EN
//   defined   : op 111 is CMP (SUB with carry forced to 1, returns A truncated to len)
//   undefined : op 111 behaves exactly as SUB
module alu_mb_seq #(
  parameter int MAX_BYTES = 4,
  parameter int LEN_W     = $clog2(MAX_BYTES) + 1
) (
  input  logic       clk,
  input  logic       reset,
  alu_mb_seq_if.slave bus,
  output logic [3:0] alu_op,
  output logic       alu_right,
  output logic [7:0] alu_ai,
  output logic [7:0] alu_bi,
  output logic       alu_ci,
  output logic       alu_bcd,
  output logic       alu_rdy,
  input  logic [7:0] alu_out,
  input  logic       alu_co,
  input  logic       alu_v
);

  localparam int DW    = 8 * MAX_BYTES;
  localparam int IDX_W = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_ASL = 3'b010;
  localparam logic [2:0] OP_ROR = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_CMP = 3'b111;

  logic [1:0]       state;
  logic [2:0]       op_q;
  logic [LEN_W-1:0] len_q;
  logic [DW-1:0]    a_q;
  logic [DW-1:0]    b_q;
  logic             ci_q;
  logic [IDX_W-1:0] idx;
  logic [LEN_W-1:0] cnt;
  logic             cap_vld;
  logic [IDX_W-1:0] cap_idx;

  logic [DW-1:0]    res_data_q;
  logic             res_c_q;
  logic             res_v_q;
  logic             res_z_q;
  logic             res_n_q;

  logic [LEN_W-1:0] len_eff;
  logic [IDX_W-1:0] idx_start;
  logic             ci_in;
  logic             is_last;
  logic             chain_ci;
  logic [DW-1:0]    data_next;
  logic [DW-1:0]    data_final;
  logic             n_next;
  logic             is_logic;
  logic             is_arith;

  // Length 0 or beyond the datapath width means "full width".
  always_comb begin
    if (bus.cmd_len == '0 || 32'(bus.cmd_len) > MAX_BYTES) begin
      len_eff = LEN_W'(MAX_BYTES);
    end else begin
      len_eff = bus.cmd_len;
    end
  end

  // ROR walks from the most significant byte down so the shifted-out bit
  // flows into the top of the next lower byte.
  always_comb begin
    if (bus.cmd_op == OP_ROR) begin
      idx_start = IDX_W'(len_eff - LEN_W'(1));
    end else begin
      idx_start = '0;
    end
  end

`ifdef ALU_MB_SEQ_CMP_EN
  assign ci_in = (bus.cmd_op == OP_CMP) ? 1'b1 : bus.cmd_ci;
`else
  assign ci_in = bus.cmd_ci;
`endif

  assign is_last  = (cnt == len_q - LEN_W'(1));
  assign is_logic = (op_q == OP_OR) || (op_q == OP_AND) || (op_q == OP_XOR);
  assign is_arith = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_CMP);

  // First issued byte has no prior result pending; later bytes take the
  // carry of the byte whose result is visible this cycle.
  assign chain_ci = cap_vld ? alu_co : ci_q;

  // ALU drive: only meaningful on issue cycles, otherwise held at 0.
  always_comb begin
    alu_op    = '0;
    alu_right = 1'b0;
    alu_ai    = '0;
    alu_bi    = '0;
    alu_ci    = 1'b0;
    alu_rdy   = 1'b0;
    if (state == S_RUN && !reset) begin
      alu_rdy = 1'b1;
      alu_ai  = a_q[8*idx +: 8];
      case (op_q)
        OP_ADD: begin
          alu_op = 4'b0011;
          alu_bi = b_q[8*idx +: 8];
          alu_ci = chain_ci;
        end
        OP_SUB, OP_CMP: begin
          alu_op = 4'b0111;
          alu_bi = b_q[8*idx +: 8];
          alu_ci = chain_ci;
        end
        OP_ASL: begin
          alu_op = 4'b1011;
          alu_ci = chain_ci;
        end
        OP_ROR: begin
          alu_op    = 4'b1111;
          alu_right = 1'b1;
          alu_ci    = chain_ci;
        end
        OP_OR: begin
          alu_op = 4'b1100;
          alu_bi = b_q[8*idx +: 8];
        end
        OP_AND: begin
          alu_op = 4'b1101;
          alu_bi = b_q[8*idx +: 8];
        end
        default: begin
          alu_op = 4'b1110;
          alu_bi = b_q[8*idx +: 8];
        end
      endcase
    end
  end

  assign alu_bcd = 1'b0;

  // Result word with the byte issued last cycle merged in.
  always_comb begin
    data_next = res_data_q;
    if (cap_vld) begin
      data_next[8*cap_idx +: 8] = alu_out;
    end
  end

  always_comb begin
    n_next = 1'b0;
    for (int unsigned i = 0; i < MAX_BYTES; i++) begin
      if (i + 1 == 32'(len_q)) begin
        n_next = data_next[8*i+7];
      end
    end
  end

`ifdef ALU_MB_SEQ_CMP_EN
  logic [DW-1:0] len_mask;

  always_comb begin
    len_mask = '0;
    for (int unsigned i = 0; i < MAX_BYTES; i++) begin
      if (i < 32'(len_q)) begin
        len_mask[8*i +: 8] = 8'hFF;
      end
    end
  end

  // CMP keeps the subtraction flags but hands back operand A.
  assign data_final = (op_q == OP_CMP) ? (a_q & len_mask) : data_next;
`else
  assign data_final = data_next;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      op_q       <= '0;
      len_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      ci_q       <= 1'b0;
      idx        <= '0;
      cnt        <= '0;
      cap_vld    <= 1'b0;
      cap_idx    <= '0;
      res_data_q <= '0;
      res_c_q    <= 1'b0;
      res_v_q    <= 1'b0;
      res_z_q    <= 1'b0;
      res_n_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            op_q       <= bus.cmd_op;
            len_q      <= len_eff;
            a_q        <= bus.cmd_a;
            b_q        <= bus.cmd_b;
            ci_q       <= ci_in;
            idx        <= idx_start;
            cnt        <= '0;
            cap_vld    <= 1'b0;
            res_data_q <= '0;
            state      <= S_RUN;
          end
        end
        S_RUN: begin
          res_data_q <= data_next;
          cap_vld    <= 1'b1;
          cap_idx    <= idx;
          cnt        <= cnt + LEN_W'(1);
          idx        <= (op_q == OP_ROR) ? idx - IDX_W'(1) : idx + IDX_W'(1);
          if (is_last) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          cap_vld    <= 1'b0;
          res_data_q <= data_final;
          res_c_q    <= is_logic ? 1'b0 : alu_co;
          res_v_q    <= is_arith ? alu_v : 1'b0;
          res_z_q    <= (data_next == '0);
          res_n_q    <= n_next;
          state      <= S_DONE;
        end
        default: begin
          if (bus.res_ready) begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.cmd_ready = (state == S_IDLE);
  assign bus.res_valid = (state == S_DONE);
  assign bus.res_data  = res_data_q;
  assign bus.res_c     = res_c_q;
  assign bus.res_v     = res_v_q;
  assign bus.res_z     = res_z_q;
  assign bus.res_n     = res_n_q;

endmodule

// File: tb/tb_alu_mb_seq.sv
// Bench for alu_mb_seq: a behavioural 6502 ALU answers the sequencer, directed
// commands push their hand-computed results into a queue, and a monitor pops
// and compares whenever a result is handed over.
module tb_alu_mb_seq;

  logic clk = 1'b0;
  logic reset;

  alu_mb_seq_if #(.MAX_BYTES(4), .LEN_W(3)) bus ();

  logic [3:0] alu_op;
  logic       alu_right;
  logic [7:0] alu_ai;
  logic [7:0] alu_bi;
  logic       alu_ci;
  logic       alu_bcd;
  logic       alu_rdy;
  logic [7:0] alu_out = 8'h00;
  logic       alu_co  = 1'b0;
  logic       alu_v   = 1'b0;

  alu_mb_seq #(.MAX_BYTES(4), .LEN_W(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .alu_op    (alu_op),
    .alu_right (alu_right),
    .alu_ai    (alu_ai),
    .alu_bi    (alu_bi),
    .alu_ci    (alu_ci),
    .alu_bcd   (alu_bcd),
    .alu_rdy   (alu_rdy),
    .alu_out   (alu_out),
    .alu_co    (alu_co),
    .alu_v     (alu_v)
  );

  always #5 clk = ~clk;

  // Behavioural 6502 ALU (binary mode): returns {V, CO, OUT}.
  function automatic logic [9:0] alu_f(input logic [3:0] op, input logic right,
                                       input logic [7:0] ai, input logic [7:0] bi,
                                       input logic ci);
    logic [8:0] tl;
    logic [7:0] tbi;
    logic       aci;
    logic [8:0] s;
    case (op[1:0])
      2'b00:   tl = {1'b0, ai | bi};
      2'b01:   tl = {1'b0, ai & bi};
      2'b10:   tl = {1'b0, ai ^ bi};
      default: tl = {1'b0, ai};
    endcase
    if (right) tl = {ai[0], ci, ai[7:1]};
    case (op[3:2])
      2'b00:   tbi = bi;
      2'b01:   tbi = ~bi;
      2'b10:   tbi = tl[7:0];
      default: tbi = 8'h00;
    endcase
    aci = (right || op[3:2] == 2'b11) ? 1'b0 : ci;
    s = tl + {1'b0, tbi} + {8'h00, aci};
    return {ai[7] ^ tbi[7] ^ s[8] ^ s[7], s[8], s[7:0]};
  endfunction

  logic [9:0] alu_r;
  always_comb alu_r = alu_f(alu_op, alu_right, alu_ai, alu_bi, alu_ci);

  always @(posedge clk) begin
    if (alu_rdy) begin
      alu_out <= alu_r[7:0];
      alu_co  <= alu_r[8];
      alu_v   <= alu_r[9];
    end
  end

  typedef struct {
    string       nm;
    logic [31:0] d;
    logic        c;
    logic        v;
    logic        z;
    logic        n;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: every completed result handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && bus.res_valid && bus.res_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected result: got data 0x%0h with nothing pending", bus.res_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.nm, " data"}, bus.res_data, e.d);
        chk({e.nm, " flags CVZN"}, 32'({bus.res_c, bus.res_v, bus.res_z, bus.res_n}),
            32'({e.c, e.v, e.z, e.n}));
      end
    end
  end

  // Issue one command from IDLE; check acceptance, latency and issue-cycle count.
  // hold > 0 keeps res_ready low for that many extra cycles in DONE while a
  // second command is presented and must be ignored.
  task automatic issue(input string nm, input logic [2:0] op, input logic [2:0] len,
                       input logic [31:0] a, input logic [31:0] b, input logic ci,
                       input int elen, input logic [31:0] ed,
                       input logic ec, input logic ev, input logic ez, input logic en,
                       input int hold);
    exp_t e;
    int   rdy_cnt;
    int   lat;
    bit   seen;
    e.nm = nm; e.d = ed; e.c = ec; e.v = ev; e.z = ez; e.n = en;
    sb.push_back(e);
    bus.res_ready = (hold == 0);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_len   = len;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_ci    = ci;
    @(negedge clk);
    chk({nm, " cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    rdy_cnt = 0;
    lat     = 0;
    seen    = 1'b0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(negedge clk);
      if (alu_rdy) rdy_cnt++;
      if (bus.res_valid) begin
        seen = 1'b1;
        lat  = k;
      end
    end
    chk({nm, " latency"}, 32'(lat), 32'(elen + 2));
    chk({nm, " alu_rdy cycles"}, 32'(rdy_cnt), 32'(elen));
    if (seen && hold > 0) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 3'b000;
      bus.cmd_len   = 3'd4;
      bus.cmd_a     = 32'hFFFF_FFFF;
      bus.cmd_b     = 32'h0000_0001;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        chk({nm, " hold res_valid"}, 32'(bus.res_valid), 32'd1);
        chk({nm, " hold data"}, bus.res_data, ed);
        chk({nm, " hold flags"}, 32'({bus.res_c, bus.res_v, bus.res_z, bus.res_n}),
            32'({ec, ev, ez, en}));
        chk({nm, " hold cmd_ready"}, 32'(bus.cmd_ready), 32'd0);
        chk({nm, " hold alu_rdy"}, 32'(alu_rdy), 32'd0);
      end
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      bus.res_ready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'b000;
    bus.cmd_len   = 3'd0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.cmd_ci    = 1'b0;
    bus.res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    chk("reset cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("reset res_valid", 32'(bus.res_valid), 32'd0);
    chk("reset res_data", bus.res_data, 32'd0);
    chk("reset flags", 32'({bus.res_c, bus.res_v, bus.res_z, bus.res_n}), 32'd0);
    chk("reset alu outputs",
        32'({alu_op, alu_right, alu_ai, alu_bi, alu_ci, alu_bcd, alu_rdy}), 32'd0);
    @(posedge clk); #1;

    //     name        op      len   A              B              ci  elen  result         C  V  Z  N  hold
    issue("add4",      3'b000, 3'd4, 32'h00FF_FFFF, 32'h0000_0001, 0,  4,    32'h0100_0000, 0, 0, 0, 0, 0);
    issue("sub2",      3'b001, 3'd2, 32'h0000_0000, 32'h0000_0001, 1,  2,    32'h0000_FFFF, 0, 0, 0, 1, 0);
    issue("add1 ovf",  3'b000, 3'd1, 32'h0000_007F, 32'h0000_0001, 0,  1,    32'h0000_0080, 0, 1, 0, 1, 0);
    issue("sub2 nb",   3'b001, 3'd2, 32'h0000_1234, 32'h0000_0034, 1,  2,    32'h0000_1200, 1, 0, 0, 0, 0);
    issue("ror4",      3'b011, 3'd4, 32'h0000_0001, 32'h0000_0000, 1,  4,    32'h8000_0000, 1, 0, 0, 1, 0);
    issue("asl1",      3'b010, 3'd1, 32'hABCD_EF80, 32'h0000_0000, 0,  1,    32'h0000_0000, 1, 0, 1, 0, 0);
    issue("xor2",      3'b110, 3'd2, 32'h1234_5AA5, 32'h9999_5AA5, 0,  2,    32'h0000_0000, 0, 0, 1, 0, 0);
    issue("add len0",  3'b000, 3'd0, 32'h1234_5678, 32'h1111_1111, 0,  4,    32'h2345_6789, 0, 0, 0, 0, 0);
    issue("and len5",  3'b101, 3'd5, 32'hF0F0_F0F0, 32'hFF00_FF00, 0,  4,    32'hF000_F000, 0, 0, 0, 1, 0);
    issue("or3",       3'b100, 3'd3, 32'h5512_0000, 32'h0000_4300, 1,  3,    32'h0012_4300, 0, 0, 0, 0, 0);
`ifdef ALU_MB_SEQ_CMP_EN
    issue("cmp1",      3'b111, 3'd1, 32'h0000_0010, 32'h0000_0020, 0,  1,    32'h0000_0010, 0, 0, 0, 1, 0);
`else
    issue("op7 sub1",  3'b111, 3'd1, 32'h0000_0010, 32'h0000_0020, 0,  1,    32'h0000_00EF, 0, 0, 0, 1, 0);
`endif
    issue("stall sub2",3'b001, 3'd2, 32'h0000_0000, 32'h0000_0001, 1,  2,    32'h0000_FFFF, 0, 0, 0, 1, 3);

    // The command presented during DONE must not have started.
    repeat (2) begin
      @(negedge clk);
      chk("after stall cmd_ready", 32'(bus.cmd_ready), 32'd1);
      chk("after stall alu_rdy", 32'(alu_rdy), 32'd0);
    end
    @(posedge clk); #1;

    // Reset in the middle of RUN.
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'b000;
    bus.cmd_len   = 3'd4;
    bus.cmd_a     = 32'h0102_0304;
    bus.cmd_b     = 32'h1111_1111;
    bus.cmd_ci    = 1'b0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("run alu_rdy", 32'(alu_rdy), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid-run reset cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("mid-run reset res_valid", 32'(bus.res_valid), 32'd0);
    chk("mid-run reset alu_rdy", 32'(alu_rdy), 32'd0);
    chk("mid-run reset res_data", bus.res_data, 32'd0);
    repeat (6) begin
      @(negedge clk);
      chk("aborted cmd stays idle", 32'({bus.cmd_ready, bus.res_valid, alu_rdy}), 32'b100);
    end
    @(posedge clk); #1;

    issue("add4 post-reset", 3'b000, 3'd4, 32'h0102_0304, 32'h1111_1111, 0, 4,
          32'h1213_1415, 0, 0, 0, 0, 0);

    for (int w = 0; w < 20 && sb.size() != 0; w++) @(posedge clk);
    chk("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_mb_seq.md
Name: alu_mb_seq

Overview:
Multi-byte arithmetic sequencer for the 8-bit 6502 ALU.
- Accepts one command of up to MAX_BYTES bytes and issues it to the ALU one byte per cycle.
- Chains the registered carry-out from one byte into the carry-in of the next.
- Collects the per-byte results and returns the assembled word with C/V/Z/N flags over a valid/ready handshake.
- Owns the ALU's op/operand/RDY inputs exclusively while a command is in flight.

Parameters:
MAX_BYTES, 4, maximum operand length in bytes; data ports are 8*MAX_BYTES wide
LEN_W, $clog2(MAX_BYTES)+1, width of cmd_len

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command (high only in IDLE)
cmd_op  input  3  000 ADD, 001 SUB, 010 ASL, 011 ROR, 100 OR, 101 AND, 110 XOR, 111 CMP/SUB
cmd_len  input  LEN_W  byte count; 0 or >MAX_BYTES treated as MAX_BYTES
cmd_a  input  8*MAX_BYTES  operand A, byte 0 = LSB
cmd_b  input  8*MAX_BYTES  operand B
cmd_ci  input  1  initial carry / shift-in bit
res_valid  output  1  result available
res_ready  input  1  result consumed
res_data  output  8*MAX_BYTES  result; bytes at index >= len are 0
res_c, res_v, res_z, res_n  output  1 each  result flags
alu_op  output  4  to ALU op
alu_right  output  1  to ALU right
alu_ai, alu_bi  output  8 each  to ALU AI, BI
alu_ci  output  1  to ALU CI
alu_bcd  output  1  to ALU BCD; always 0
alu_rdy  output  1  to ALU RDY; high only on issue cycles
alu_out  input  8  ALU OUT (registered; valid the cycle after issue)
alu_co, alu_v  input  1 each  ALU CO and V

Behaviour:
- Reset values:
  - State is IDLE.
  - cmd_ready=1; res_valid=0.
  - res_data=0; all result flags 0.
  - All alu_* outputs are 0.
- States:
  - IDLE: when cmd_valid&&cmd_ready, latch the command into internal registers and go to RUN.
  - RUN: issue one byte per cycle with alu_rdy=1. Move to DRAIN in the same cycle the last byte is issued.
  - DRAIN: alu_rdy=0; capture the last byte's result, then go to DONE.
  - DONE: res_valid=1 and outputs held stable until res_ready; then go to IDLE.
- Byte order:
  - ROR: MSB first, byte len-1 down to 0.
  - All other ops: LSB first.
- Per-byte mapping (alu_op / alu_right / alu_bi / alu_ci):
  - ADD: 0011 / 0 / B byte / chained.
  - SUB: 0111 / 0 / B byte / chained. cmd_ci=1 means no borrow.
  - ASL: 1011 / 0 / 0 / chained; cmd_ci shifts into bit 0.
  - ROR: 1111 / 1 / 0 / chained; cmd_ci shifts into the top bit.
  - OR / AND / XOR: 1100 / 1101 / 1110, right=0, B byte, ci=0.
- Chaining: the first issued byte uses cmd_ci. Each later byte uses alu_co, combinationally, in the cycle the previous result is visible.
- Capture: the result of byte issued in cycle t is taken from alu_out at the end of cycle t+1.
- Latency: acceptance at cycle 0 gives res_valid high in cycle len+2. Throughput is one command per len+3 cycles.
- Flags:
  - res_c: alu_co of the last issued byte; 0 for logic ops.
  - res_v: alu_v of the last issued byte for ADD/SUB/CMP; 0 otherwise.
  - res_n: bit 8*len-1 of the result.
  - res_z: 1 iff all len result bytes are 0.
- Boundaries:
  - cmd_valid is ignored outside IDLE.
  - cmd_len=1 gives one issue cycle.
  - res_ready held low keeps DONE indefinitely; outputs do not change.
  - Reset in any state returns to IDLE next cycle, drops the command, and forces alu_rdy=0.

Optional Feature:
ALU_MB_SEQ_CMP_EN
- Defined: op 111 is CMP.
  - Executes as SUB with cmd_ci ignored and forced to 1.
  - Flags are per SUB.
  - res_data returns cmd_a truncated to len bytes; higher bytes are 0.
- Undefined: op 111 executes exactly as SUB, including use of cmd_ci.

Test Plan:
- ADD len=4, A=0x00FFFFFF, B=0x00000001, ci=0 -> res_data=0x01000000, C=0 V=0 Z=0 N=0; res_valid in cycle 6 after accept; alu_rdy high exactly 4 cycles.
- SUB len=2, A=0x0000, B=0x0001, ci=1 -> 0xFFFF, C=0 N=1 Z=0 V=0; ADD len=1 0x7F+0x01 -> 0x80, V=1 N=1.
- ROR len=4, A=0x00000001, ci=1 -> 0x80000000, C=1 N=1; ASL len=1, A=0x80, ci=0 -> 0x00, C=1 Z=1, upper result bytes 0.
- XOR len=2, A=0x5AA5, B=0x5AA5 -> 0x0000, Z=1 C=0 V=0; cmd_len=0 executes 4 bytes.
- res_ready low 3 cycles in DONE -> res_* stable, cmd_ready=0, second cmd_valid ignored; reset asserted during RUN -> next cycle cmd_ready=1, res_valid=0, alu_rdy=0.
- With ALU_MB_SEQ_CMP_EN: op 111 len=1, A=0x10, B=0x20, ci=0 -> res_data=0x10, C=0 N=1 Z=0; without it the same stimulus gives res_data=0xEF, C=0 N=1.
